// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and types for the DDS waveform generator.
//   - Default widths for the phase accumulator, DAC sample and quarter-wave ROM.
//   - wave_e: waveform select encoding carried alongside each sample.
//   - DAC_MID: offset-binary midscale code (the zero-amplitude level).
package dds_pkg;

  localparam int unsigned PHASE_W_DEF = 24;
  localparam int unsigned DAC_W_DEF   = 10;
  localparam int unsigned LUT_AW_DEF  = 8;
  localparam int unsigned DAC_MID     = 512;

  typedef enum logic [1:0] {
    WAVE_SIN = 2'd0,
    WAVE_SQR = 2'd1,
    WAVE_TRI = 2'd2,
    WAVE_SAW = 2'd3
  } wave_e;

endpackage

// File: rtl/dds_quarter_sin_rom.sv
// dds_quarter_sin_rom: registered quarter-wave sine magnitude ROM.
//   ROM[i] = round((2^(DAC_W-1)-1) * sin((i+0.5)*pi/2^(LUT_AW+1))), i.e. 2..511 at defaults.
// Ports:
//   clk   in   clock
//   addr  in   LUT_AW   folded quarter-wave index
//   mag   out  DAC_W-1  magnitude, valid one clock after addr
module dds_quarter_sin_rom #(
  parameter int unsigned LUT_AW = 8,
  parameter int unsigned DAC_W  = 10
) (
  input  logic              clk,
  input  logic [LUT_AW-1:0] addr,
  output logic [DAC_W-2:0]  mag
);

  localparam int unsigned Depth = 2 ** LUT_AW;
  // pi in Q30 fixed point
  localparam longint PiQ = 64'sd3373259426;

  // Elaboration-time table entry: Taylor series for sin in Q30, odd terms up to x^17.
  function automatic logic [DAC_W-2:0] sin_entry(input int unsigned i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint v;
    x    = ((2 * longint'(i) + 1) * PiQ) >>> (LUT_AW + 2);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -(term * x2) / (longint'(1) <<< 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    v = (longint'((1 << (DAC_W - 1)) - 1) * sum + (longint'(1) <<< 29)) >>> 30;
    return v[DAC_W-2:0];
  endfunction

  logic [DAC_W-2:0] rom [Depth];

  for (genvar gi = 0; gi < Depth; gi++) begin : g_rom
    localparam logic [DAC_W-2:0] Entry = sin_entry(gi);
    assign rom[gi] = Entry;
  end

  always_ff @(posedge clk) begin
    mag <= rom[addr];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator waveform source (sine/square/triangle/sawtooth) producing
// offset-binary DAC samples. One accumulator step per sample_en; sample out 3 cycles later.
// FTW / waveform changes are staged in pending registers and applied on a phase wrap.
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   ftw_in        in   PHASE_W  new frequency tuning word
//   ftw_load      in   strobe: capture ftw_in / wave_sel as pending
//   wave_sel      in   2  waveform (0 sine, 1 square, 2 triangle, 3 sawtooth)
//   sample_en     in   advance accumulator and launch one sample
//   dac_out       out  DAC_W  sample, held between valids
//   dac_valid     out  one-cycle pulse when dac_out updates
//   busy_pending  out  a loaded FTW/wave is waiting for a wrap
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int unsigned         PHASE_W     = PHASE_W_DEF,
  parameter int unsigned         DAC_W       = DAC_W_DEF,
  parameter int unsigned         LUT_AW      = LUT_AW_DEF,
  parameter logic [PHASE_W-1:0]  FTW_DEFAULT = PHASE_W'(24'h00_4000)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] ftw_in,
  input  logic               ftw_load,
  input  logic [1:0]         wave_sel,
  input  logic               sample_en,
  output logic [DAC_W-1:0]   dac_out,
  output logic               dac_valid,
  output logic               busy_pending
);

  // Only the top phase bits are needed downstream (triangle uses the most).
  localparam int unsigned TopW = DAC_W + 1;
  localparam logic [DAC_W-1:0] Mid   = DAC_W'(DAC_MID);
  localparam logic [DAC_W-1:0] MidM1 = DAC_W'(DAC_MID - 1);

  // Stage 0: accumulator and pending update
  logic [PHASE_W-1:0] acc_q, ftw_act_q, pend_ftw_q, acc_sum;
  wave_e              wave_act_q, pend_wave_q;
  logic               pend_valid_q, wrap, apply;
  logic               s0_valid_q;
  logic [TopW-1:0]    s0_top_q;
  wave_e              s0_wave_q;

  always_comb begin
    {wrap, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_act_q};
    // A zero FTW never wraps, so pending values would otherwise wait forever.
    apply = sample_en & pend_valid_q & (wrap | (ftw_act_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      ftw_act_q    <= FTW_DEFAULT;
      wave_act_q   <= WAVE_SIN;
      pend_valid_q <= 1'b0;
      pend_ftw_q   <= '0;
      pend_wave_q  <= WAVE_SIN;
      s0_valid_q   <= 1'b0;
      s0_top_q     <= '0;
      s0_wave_q    <= WAVE_SIN;
    end else begin
      s0_valid_q <= sample_en;
      if (sample_en) begin
        acc_q     <= acc_sum;
        s0_top_q  <= acc_q[PHASE_W-1 -: TopW];
        s0_wave_q <= wave_act_q;
      end
      if (apply) begin
        ftw_act_q    <= pend_ftw_q;
        wave_act_q   <= pend_wave_q;
        pend_valid_q <= 1'b0;
      end
      // A coincident load wins the pending slot; the wrap above used the older value.
      if (ftw_load) begin
        pend_ftw_q   <= ftw_in;
        pend_wave_q  <= wave_e'(wave_sel);
        pend_valid_q <= 1'b1;
      end
    end
  end

  assign busy_pending = pend_valid_q;

  // Stage 1: quadrant fold and non-sine waveforms
  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;
  logic [DAC_W-1:0]  tri_val, alt_val;

  always_comb begin
    quad    = s0_top_q[TopW-1 -: 2];
    idx     = s0_top_q[TopW-3 -: LUT_AW];
    if (quad[0]) idx = ~idx;
    tri_val = s0_top_q[TopW-1] ? ~s0_top_q[DAC_W-1:0] : s0_top_q[DAC_W-1:0];
    alt_val = '0;
    case (s0_wave_q)
      WAVE_SIN: alt_val = '0;
      WAVE_SQR: alt_val = s0_top_q[TopW-1] ? '0 : '1;
      WAVE_TRI: alt_val = tri_val;
      WAVE_SAW: alt_val = s0_top_q[TopW-1 -: DAC_W];
    endcase
  end

  // Stage 2: ROM read, side data registered alongside
  logic [DAC_W-2:0] mag;
  logic             s1_valid_q, s1_neg_q;
  wave_e            s1_wave_q;
  logic [DAC_W-1:0] s1_alt_q;

  dds_quarter_sin_rom #(
    .LUT_AW (LUT_AW),
    .DAC_W  (DAC_W)
  ) u_rom (
    .clk  (clk),
    .addr (idx),
    .mag  (mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_wave_q  <= WAVE_SIN;
      s1_alt_q   <= '0;
    end else begin
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_neg_q  <= quad[1];
        s1_wave_q <= s0_wave_q;
        s1_alt_q  <= alt_val;
      end
    end
  end

  // Stage 3: output
  logic [DAC_W-1:0] out_val, dac_q;
  logic             dac_valid_q;

  always_comb begin
    if (s1_wave_q == WAVE_SIN) begin
      out_val = s1_neg_q ? (MidM1 - {1'b0, mag}) : (Mid + {1'b0, mag});
    end else begin
      out_val = s1_alt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_q       <= Mid;
      dac_valid_q <= 1'b0;
    end else begin
      dac_valid_q <= s1_valid_q;
      if (s1_valid_q) dac_q <= out_val;
    end
  end

  assign dac_out   = dac_q;
  assign dac_valid = dac_valid_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: directed + randomized stimulus against a behavioural DDS model.
module tb_dds_wave_gen;

  localparam real PI = 3.14159265358979323846;
  localparam longint PMOD = longint'(1) << 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] ftw_in = '0;
  logic        ftw_load = 1'b0;
  logic [1:0]  wave_sel = '0;
  logic        sample_en = 1'b0;
  logic [9:0]  dac_out;
  logic        dac_valid;
  logic        busy_pending;

  always #5 clk = ~clk;

  dds_wave_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ftw_in       (ftw_in),
    .ftw_load     (ftw_load),
    .wave_sel     (wave_sel),
    .sample_en    (sample_en),
    .dac_out      (dac_out),
    .dac_valid    (dac_valid),
    .busy_pending (busy_pending)
  );

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model state
  longint m_acc, m_ftw, m_pftw;
  int     m_wave, m_pwave;
  bit     m_pend;
  bit     d_v [2];
  int     d_val [2];
  bit     m_valid;
  int     m_out;

  // Ideal sample for a phase: 1024 points per cycle, sine magnitude rounded from the
  // point midway through each 1/1024 slot.
  function automatic int wave_value(input longint ph, input int w);
    real a;
    real s;
    int  k;
    int  m;
    int  u;
    k = int'(ph >> 14);
    case (w)
      0: begin
        a = (real'(k) + 0.5) * 2.0 * PI / 1024.0;
        s = $sin(a);
        m = $rtoi(511.0 * (s < 0.0 ? -s : s) + 0.5);
        return (s >= 0.0) ? 512 + m : 511 - m;
      end
      1: return (((ph >> 23) & 1) != 0) ? 0 : 1023;
      2: begin
        u = int'(ph >> 13);
        return (u < 1024) ? u : 2047 - u;
      end
      default: return k;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ftw = 'h4000; m_wave = 0; m_pend = 0; m_pftw = 0; m_pwave = 0;
    d_v[0] = 0; d_v[1] = 0; d_val[0] = 0; d_val[1] = 0;
    m_valid = 0; m_out = 512;
  endtask

  // One clock edge with the inputs that were presented during the preceding cycle.
  task automatic model_edge(input bit se, input bit ld, input longint fin, input int ws);
    longint sum;
    bit     wrap;
    m_valid = d_v[1];
    if (d_v[1]) m_out = d_val[1];
    d_v[1] = d_v[0]; d_val[1] = d_val[0];
    d_v[0] = se;
    if (se) begin
      d_val[0] = wave_value(m_acc, m_wave);
      sum  = m_acc + m_ftw;
      wrap = (sum >= PMOD);
      if (m_pend && (wrap || m_ftw == 0)) begin
        m_ftw = m_pftw; m_wave = m_pwave; m_pend = 0;
      end
      m_acc = sum % PMOD;
    end
    if (ld) begin
      m_pftw = fin; m_pwave = ws; m_pend = 1;
    end
  endtask

  task automatic cycle(input bit se, input bit ld, input longint fin, input int ws);
    sample_en = se;
    ftw_load  = ld;
    ftw_in    = fin[23:0];
    wave_sel  = ws[1:0];
    @(posedge clk);
    #1;
    model_edge(se, ld, fin, ws);
    check_val("valid", longint'(dac_valid), longint'(m_valid));
    check_val("out", longint'(dac_out), longint'(m_out));
    check_val("busy", longint'(busy_pending), longint'(m_pend));
  endtask

  task automatic rand_cycles(input int n);
    longint fin;
    int     r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0: fin = longint'($urandom & 32'h00FF_FFFF);
        1: fin = longint'(1) << $urandom_range(16, 23);
        2: fin = 0;
        default: fin = longint'($urandom_range(1, 255)) << 16;
      endcase
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), fin,
            int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out", longint'(dac_out), 512);
    check_val("rst_valid", longint'(dac_valid), 0);
    check_val("rst_busy", longint'(busy_pending), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default FTW, continuous sampling: first valid 3 cycles after first sample_en.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_val("pre_first_valid", longint'(dac_valid), 0);
    check_val("pre_first_out", longint'(dac_out), 512);
    cycle(1, 0, 0, 0);
    check_val("first_valid", longint'(dac_valid), 1);
    check_val("first_out", longint'(dac_out), 514);
    repeat (10) cycle(1, 0, 0, 0);

    // Switch to FTW 2^22 sine; applies at the wrap after the 1024-step default period.
    cycle(1, 1, longint'(1) << 22, 0);
    repeat (1030) cycle(1, 0, 0, 0);
    check_val("sin4_busy_clear", longint'(busy_pending), 0);
    repeat (12) cycle(1, 0, 0, 0);

    // Square at 2^20 loaded mid-cycle, then two loads before a wrap (last wins).
    cycle(1, 0, 0, 0);
    cycle(1, 1, longint'(1) << 20, 1);
    check_val("sqr_busy", longint'(busy_pending), 1);
    repeat (40) cycle(1, 0, 0, 0);
    cycle(1, 1, longint'(1) << 20, 1);
    cycle(1, 1, longint'(1) << 21, 1);
    repeat (40) cycle(1, 0, 0, 0);

    // Sawtooth then triangle at 2^14.
    cycle(1, 1, longint'(1) << 14, 3);
    repeat (1100) cycle(1, 0, 0, 0);
    cycle(1, 1, longint'(1) << 14, 2);
    repeat (2100) cycle(1, 0, 0, 0);

    // Randomized traffic, covering loads coincident with wraps and zero FTW.
    rand_cycles(3000);

    // Reset with samples in flight and a pending load.
    cycle(1, 1, 5, 2);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_out", longint'(dac_out), 512);
    check_val("arst_valid", longint'(dac_valid), 0);
    check_val("arst_busy", longint'(busy_pending), 0);
    model_reset();
    sample_en = 1'b0;
    ftw_load  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("arst_hold_valid", longint'(dac_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(0, 0, 0, 0);
    repeat (20) cycle(1, 0, 0, 0);

    rand_cycles(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
